// File: rtl/key_scan_multi.sv
// key_scan_multi
//   Multi-channel key front end: per key a 2-flop synchroniser, a symmetric
//   debounce filter, one-cycle press/release strobes, long-press detection
//   and (optionally) auto-repeat while the key stays held after a long press.
//
// Optional feature macro: KEY_SCAN_REPEAT_EN
//   defined   : LONG state emits f_key_repeat every REPEAT_CYCLES until release.
//   undefined : no repeat counter is built, f_key_repeat is tied to 0 and
//               LONG is a terminal hold state until release.
//
// Ports
//   FPGA_CLK      in   system clock
//   RESET         in   synchronous, active-high reset
//   KEY           in   [N_KEYS] raw asynchronous key pins
//   key_state     out  [N_KEYS] debounced level, 1 = pressed
//   f_key_down    out  [N_KEYS] one-cycle strobe on accepted press
//   f_key_up      out  [N_KEYS] one-cycle strobe on accepted release
//   f_key_long    out  [N_KEYS] one-cycle strobe when a press reaches LONG_CYCLES
//   f_key_repeat  out  [N_KEYS] one-cycle auto-repeat strobe
//
// Hold FSM per channel (IDLE -> HELD -> LONG). An accepted release returns
// the channel to IDLE on the same edge and suppresses any long/repeat strobe
// that would otherwise land on that edge.
module key_scan_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic              FPGA_CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] f_key_down,
  output logic [N_KEYS-1:0] f_key_up,
  output logic [N_KEYS-1:0] f_key_long,
  output logic [N_KEYS-1:0] f_key_repeat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef KEY_SCAN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  // Elaboration-time guard on the timing parameters.
  if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("key_scan_multi: invalid timing parameters");
  end

  // Synchroniser holds raw pin levels; reset value is the released pin level
  // so a key held through reset is seen as a fresh press afterwards.
  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] sync_2;
  logic [N_KEYS-1:0] s_lvl;

  always_ff @(posedge FPGA_CLK) begin
    if (RESET) begin
      sync_1 <= {N_KEYS{ACTIVE_LOW}};
      sync_2 <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      sync_1 <= KEY;
      sync_2 <= sync_1;
    end
  end

  // Normalised level: 1 = pressed regardless of pin polarity.
  assign s_lvl = sync_2 ^ {N_KEYS{ACTIVE_LOW}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_cnt_nx;
    logic              level;
    logic              level_nx;
    logic              acc_down;
    logic              acc_up;
    hold_state_t       state;
    hold_state_t       state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nx;
    logic              down_q;
    logic              up_q;
    logic              long_q;
    logic              long_nx;
`ifdef KEY_SCAN_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_cnt_nx;
    logic              rep_q;
    logic              rep_nx;
`endif

    // Debounce: the counter only runs while the synchronised level differs
    // from the accepted one; any return to the accepted level clears it.
    always_comb begin
      deb_cnt_nx = '0;
      level_nx   = level;
      acc_down   = 1'b0;
      acc_up     = 1'b0;
      if (s_lvl[i] != level) begin
        if (deb_cnt == DEB_LAST) begin
          level_nx = s_lvl[i];
          acc_down = s_lvl[i];
          acc_up   = ~s_lvl[i];
        end else begin
          deb_cnt_nx = deb_cnt + 1'b1;
        end
      end
    end

    // Hold FSM next-state and strobe logic.
    always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      long_nx     = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
      rep_cnt_nx  = rep_cnt;
      rep_nx      = 1'b0;
`endif
      case (state)
        IDLE: begin
          if (acc_down) begin
            state_nx    = HELD;
            hold_cnt_nx = '0;
          end
        end
        HELD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx    = LONG;
            hold_cnt_nx = '0;
            long_nx     = 1'b1;
`ifdef KEY_SCAN_REPEAT_EN
            rep_cnt_nx  = '0;
`endif
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
        LONG: begin
`ifdef KEY_SCAN_REPEAT_EN
          if (rep_cnt == REP_LAST) begin
            rep_cnt_nx = '0;
            rep_nx     = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state_nx    = IDLE;
          hold_cnt_nx = '0;
        end
      endcase

      // Release wins over any count boundary reached on the same edge.
      if (acc_up) begin
        state_nx    = IDLE;
        hold_cnt_nx = '0;
        long_nx     = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rep_cnt_nx  = '0;
        rep_nx      = 1'b0;
`endif
      end
    end

    always_ff @(posedge FPGA_CLK) begin
      if (RESET) begin
        deb_cnt  <= '0;
        level    <= 1'b0;
        state    <= IDLE;
        hold_cnt <= '0;
        down_q   <= 1'b0;
        up_q     <= 1'b0;
        long_q   <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rep_cnt  <= '0;
        rep_q    <= 1'b0;
`endif
      end else begin
        deb_cnt  <= deb_cnt_nx;
        level    <= level_nx;
        state    <= state_nx;
        hold_cnt <= hold_cnt_nx;
        down_q   <= acc_down;
        up_q     <= acc_up;
        long_q   <= long_nx;
`ifdef KEY_SCAN_REPEAT_EN
        rep_cnt  <= rep_cnt_nx;
        rep_q    <= rep_nx;
`endif
      end
    end

    assign key_state[i]  = level;
    assign f_key_down[i] = down_q;
    assign f_key_up[i]   = up_q;
    assign f_key_long[i] = long_q;
`ifdef KEY_SCAN_REPEAT_EN
    assign f_key_repeat[i] = rep_q;
`endif
  end

`ifndef KEY_SCAN_REPEAT_EN
  assign f_key_repeat = '0;
`endif

endmodule

// File: doc/key_scan_multi.md
Name: key_scan_multi

Overview:
- Parametrised, multi-channel successor to the single-key debouncer used on the Omdazz board tops.
- Per key: 2-flop synchroniser, symmetric debounce filter (press and release), one-cycle press and release strobes, long-press detection and optional auto-repeat.
- Drives counters, buzzer toggles and menu logic in tops.
- Tops generate RESET by inverting the active-low reset button.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEB_CYCLES, 1000000, cycles a synchronised level must stay stable before it is accepted (20 ms at 50 MHz); must be ≥ 2.
- LONG_CYCLES, 50000000, cycles of continuous debounced press before the long-press strobe (1 s); must be > DEB_CYCLES.
- REPEAT_CYCLES, 10000000, auto-repeat period after long press (200 ms); must be ≥ 2.
- ACTIVE_LOW, 1, 1 = pressed key reads 0 on the pin; 0 = pressed reads 1.

Ports:
- FPGA_CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  N_KEYS  raw asynchronous key pins.
- key_state  out  N_KEYS  debounced level, 1 = pressed.
- f_key_down  out  N_KEYS  one-cycle strobe on accepted press.
- f_key_up  out  N_KEYS  one-cycle strobe on accepted release.
- f_key_long  out  N_KEYS  one-cycle strobe when a press reaches LONG_CYCLES.
- f_key_repeat  out  N_KEYS  one-cycle auto-repeat strobe.

Behaviour:
- Clock and reset: single clock FPGA_CLK. RESET is synchronous and active-high.
- Reset values: all outputs 0. Synchroniser flops reset to the released level. Counters 0. Hold FSM in IDLE.
- Channel independence: channels are fully independent. No priority; simultaneous events on different channels all strobe in the same cycle.
- Synchroniser: 2 flops, inverted when ACTIVE_LOW=1. Output s = 1 means pressed.
- Debounce counter: width $clog2(DEB_CYCLES).
  - s == key_state: counter cleared.
  - s != key_state: counter increments.
  - On the edge where the counter == DEB_CYCLES-1: key_state <= s and the counter clears. On the same edge, f_key_down (s=1) or f_key_up (s=0) registers high for exactly one cycle.
  - Any glitch shorter than DEB_CYCLES clears the counter and produces no strobe.
  - Latency: a clean pin change sampled at edge k gives key_state change and strobe at edge k+1+DEB_CYCLES.
- Hold FSM (per channel), states IDLE, HELD, LONG:
  - IDLE: on f_key_down go to HELD and clear hold_cnt.
  - HELD: hold_cnt increments each cycle while key_state=1. At hold_cnt == LONG_CYCLES-1, pulse f_key_long, go to LONG, clear rep_cnt.
  - LONG: rep_cnt increments. At REPEAT_CYCLES-1, pulse f_key_repeat and wrap rep_cnt to 0.
  - Any state: key_state falling (f_key_up) returns to IDLE in the same edge. No long/repeat strobe is issued on that edge, even if the count boundary coincides.
- Counter widths: hold_cnt is $clog2(LONG_CYCLES) wide; rep_cnt is $clog2(REPEAT_CYCLES) wide. Counters never overflow; they are cleared on every state exit.
- Reset mid-operation: RESET clears everything with no strobes.
  - If a key is physically held through reset, it is re-accepted as a fresh press DEB_CYCLES+2 cycles after RESET deasserts.
  - That press gives f_key_down, and the long timing restarts.
- Strobe ordering: f_key_down and f_key_long are never asserted in the same cycle on one channel; this is guaranteed by LONG_CYCLES > DEB_CYCLES.

Optional Feature:
- Macro: KEY_SCAN_REPEAT_EN.
- Defined: auto-repeat as described. The LONG state emits f_key_repeat every REPEAT_CYCLES until release.
- Undefined: rep_cnt is not built. f_key_repeat is tied to 0. LONG is a terminal hold state until release. REPEAT_CYCLES is ignored. All other behaviour is identical.

Test Plan:
All scenarios use DEB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10, N_KEYS=4, ACTIVE_LOW=1.
1. Bounce: KEY[0] toggles low/high with 3-cycle pulses for 30 cycles, then held low -> no strobe during bounce; exactly one f_key_down[0] and key_state[0]=1 at 1+8 edges after the final stable low sample.
2. Glitch reject: KEY[1] low for 7 cycles, then high -> key_state[1] stays 0; no strobes on any channel.
3. Long press with repeat: KEY[2] held low 80 cycles after acceptance (macro defined) -> f_key_long[2] at 40 cycles after f_key_down[2]; f_key_repeat[2] at +10, +20, +30, +40 after it; on release, one f_key_up[2] after 8 cycles and no further repeats. With the macro undefined -> same f_key_long, zero repeats.
4. Release at boundary: release timed so the debounced release lands on the same edge hold_cnt reaches 39 -> f_key_up only, no f_key_long, FSM back to IDLE.
5. Reset mid-hold: KEY[3] held, RESET high for 2 cycles while in LONG -> all outputs 0 during reset; after deassert, f_key_down[3] at DEB_CYCLES+2=10 cycles, f_key_long[3] 40 cycles later.
6. Simultaneous: KEY[0] and KEY[3] pressed on the same cycle -> f_key_down[0] and f_key_down[3] assert on the same edge; the other channels stay 0.
